// File: rtl/mdu_serial.sv
// RV32M multiply/divide unit: one-cycle 33x33 multiply, 32-iteration restoring divide,
// division corner cases resolved at accept. One tagged writeback pulse per accepted op.
module mdu_serial #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IdxWidth = 3
) (
    input  logic                clock,
    input  logic                rst_ni,
    input  logic                mdu_valid,
    input  logic [XLEN-1:0]     operand_a,
    input  logic [XLEN-1:0]     operand_b,
    input  logic [2:0]          operation,
    input  logic [IdxWidth-1:0] trans_id,
    output logic                mdu_ready,
    output logic                result_valid,
    output logic [XLEN-1:0]     result,
    output logic [IdxWidth-1:0] result_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] Zero   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] Ones   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] x);
        return Zero - x;
    endfunction

    // Magnitude of a signed operand; the most negative value maps to itself read as unsigned.
    function automatic logic [XLEN-1:0] abs_f(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? neg_f(x) : x;
    endfunction

    state_e                state_q, state_d;
    logic [XLEN-1:0]       opa_q, opa_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic [XLEN-1:0]       rem_q, rem_d;
    logic [1:0]            op_q, op_d;
    logic [IdxWidth-1:0]   tid_q, tid_d;
    logic [4:0]            cnt_q, cnt_d;
    logic                  negq_q, negq_d;
    logic                  negr_q, negr_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic [IdxWidth-1:0]   result_id_q, result_id_d;

    logic                  start_s;
    logic                  is_div_s;
    logic                  sgn_div_s;
    logic                  b_zero_s;
    logic                  ovf_s;
    logic                  special_s;
    logic [XLEN-1:0]       special_res_s;
    logic                  sign_a_s;
    logic                  sign_b_s;
    logic [2*XLEN-1:0]     ext_a_s;
    logic [2*XLEN-1:0]     ext_b_s;
    logic [2*XLEN-1:0]     prod_s;
    logic [XLEN:0]         rem_shift_s;
    logic [XLEN:0]         diff_s;
    logic [XLEN-1:0]       rem_next_s;
    logic [XLEN-1:0]       quo_next_s;
    logic [XLEN-1:0]       div_res_s;

    // Accept decode and division corner-case detection on the raw inputs.
    always_comb begin
        start_s   = mdu_valid && (state_q == S_IDLE);
        is_div_s  = operation[2];
        sgn_div_s = ~operation[0];
        b_zero_s  = (operand_b == Zero);
        ovf_s     = sgn_div_s && (operand_a == MinInt) && (operand_b == Ones);
        special_s = is_div_s && (b_zero_s || ovf_s);
        if (b_zero_s) begin
            special_res_s = operation[1] ? operand_a : Ones;
        end else begin
            special_res_s = operation[1] ? Zero : MinInt;
        end
    end

    // Multiply and one restoring-division step on the latched operands.
    always_comb begin
        sign_a_s    = (op_q != 2'd3);
        sign_b_s    = ~op_q[1];
        ext_a_s     = {{XLEN{sign_a_s & opa_q[XLEN-1]}}, opa_q};
        ext_b_s     = {{XLEN{sign_b_s & opb_q[XLEN-1]}}, opb_q};
        prod_s      = ext_a_s * ext_b_s;
        rem_shift_s = {rem_q, opa_q[XLEN-1]};
        diff_s      = rem_shift_s - {1'b0, opb_q};
        if (!diff_s[XLEN]) begin
            rem_next_s = diff_s[XLEN-1:0];
            quo_next_s = {opa_q[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[XLEN-1:0];
            quo_next_s = {opa_q[XLEN-2:0], 1'b0};
        end
        if (op_q[1]) begin
            div_res_s = negr_q ? neg_f(rem_next_s) : rem_next_s;
        end else begin
            div_res_s = negq_q ? neg_f(quo_next_s) : quo_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    if (!is_div_s) begin
                        state_d = S_MUL;
                    end else if (special_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL:   state_d = S_DONE;
            S_DIV:   state_d = (cnt_q == 5'd0) ? S_DONE : S_DIV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath register updates per state.
    always_comb begin
        opa_d       = opa_q;
        opb_d       = opb_q;
        rem_d       = rem_q;
        op_d        = op_q;
        tid_d       = tid_q;
        cnt_d       = cnt_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    op_d   = operation[1:0];
                    tid_d  = trans_id;
                    opa_d  = is_div_s ? abs_f(operand_a, sgn_div_s) : operand_a;
                    opb_d  = is_div_s ? abs_f(operand_b, sgn_div_s) : operand_b;
                    rem_d  = Zero;
                    cnt_d  = 5'd31;
                    negq_d = sgn_div_s && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
                    negr_d = sgn_div_s && operand_a[XLEN-1];
                    if (special_s) begin
                        result_d    = special_res_s;
                        result_id_d = trans_id;
                    end else begin
                        result_d    = result_q;
                        result_id_d = result_id_q;
                    end
                end else begin
                    op_d = op_q;
                end
            end
            S_MUL: begin
                result_d    = (op_q == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                result_id_d = tid_q;
            end
            S_DIV: begin
                opa_d = quo_next_s;
                rem_d = rem_next_s;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d    = div_res_s;
                    result_id_d = tid_q;
                end else begin
                    result_d    = result_q;
                    result_id_d = result_id_q;
                end
            end
            S_DONE:  cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            opa_q       <= Zero;
            opb_q       <= Zero;
            rem_q       <= Zero;
            op_q        <= 2'd0;
            tid_q       <= {IdxWidth{1'b0}};
            cnt_q       <= 5'd0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            result_q    <= Zero;
            result_id_q <= {IdxWidth{1'b0}};
        end else begin
            state_q     <= state_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rem_q       <= rem_d;
            op_q        <= op_d;
            tid_q       <= tid_d;
            cnt_q       <= cnt_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
        end
    end

    // Outputs decoded from registered state and result registers.
    always_comb begin
        mdu_ready    = (state_q == S_IDLE);
        result_valid = (state_q == S_DONE);
        result       = result_q;
        result_id    = result_id_q;
    end

endmodule

// File: tb/tb_mdu_serial.sv
// Scoreboard bench for mdu_serial: directed RV32M vectors, latency and id checks, reset abort.
module tb_mdu_serial;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mdu_valid = 1'b0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic [2:0]  operation = 3'd0;
    logic [2:0]  trans_id = 3'd0;
    logic        mdu_ready;
    logic        result_valid;
    logic [31:0] result;
    logic [2:0]  result_id;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;

    mdu_serial #(.XLEN(32), .IdxWidth(3)) dut (
        .clock       (clk),
        .rst_ni      (rst_ni),
        .mdu_valid   (mdu_valid),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .operation   (operation),
        .trans_id    (trans_id),
        .mdu_ready   (mdu_ready),
        .result_valid(result_valid),
        .result      (result),
        .result_id   (result_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every writeback pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wb got id=%0d data=%h at cyc=%0d, required no writeback",
                         result_id, result, cyc);
            end else begin
                e = sb_q.pop_front();
                n_pop++;
                if (result !== e.data || result_id !== e.id || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL wb got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d",
                             result_id, result, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Waits for mdu_ready, drives a one-cycle start; returns at the negedge of the cycle after accept.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] id, input logic [31:0] exp_v, input int lat,
                         input bit push);
        exp_t e;
        int guard;
        guard = 0;
        @(negedge clk);
        while (!mdu_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            total++;
            bad++;
            $display("FAIL ready_timeout got=0 required=1");
        end
        operation = op;
        operand_a = a;
        operand_b = b;
        trans_id  = id;
        mdu_valid = 1'b1;
        if (push) begin
            e.id   = id;
            e.data = exp_v;
            e.cyc  = cyc + lat;
            sb_q.push_back(e);
            n_push++;
        end
        @(negedge clk);
        mdu_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", sb_q.size(), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_ready", {31'd0, mdu_ready}, 32'd1);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_id", {29'd0, result_id}, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        issue(OP_MUL,    32'd7,        32'hFFFFFFFD, 3'd5, 32'hFFFFFFEB, 2, 1'b1);
        issue(OP_MULH,   32'h80000000, 32'h80000000, 3'd1, 32'h40000000, 2, 1'b1);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, 2, 1'b1);
        issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, 2, 1'b1);
        issue(OP_MUL,    32'h12345678, 32'h00000010, 3'd4, 32'h23456780, 2, 1'b1);
        issue(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd6, 32'h00000000, 2, 1'b1);

        issue(OP_DIV,  32'hFFFFFFF9, 32'd2, 3'd1, 32'hFFFFFFFD, 33, 1'b1);
        issue(OP_REM,  32'hFFFFFFF9, 32'd2, 3'd2, 32'hFFFFFFFF, 33, 1'b1);
        issue(OP_DIVU, 32'd100,      32'd7, 3'd3, 32'd14,       33, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            check("busy_ready", {31'd0, mdu_ready}, 32'd0);
            @(negedge clk);
        end
        check("ready_after_div", {31'd0, mdu_ready}, 32'd1);
        issue(OP_REMU, 32'd100,        32'd7,          3'd4, 32'd2,        33, 1'b1);
        issue(OP_DIV,  32'd7,          32'hFFFFFFFE,   3'd5, 32'hFFFFFFFD, 33, 1'b1);
        issue(OP_REM,  32'd7,          32'hFFFFFFFE,   3'd6, 32'd1,        33, 1'b1);
        issue(OP_DIV,  32'h80000000,   32'd2,          3'd7, 32'hC0000000, 33, 1'b1);

        issue(OP_DIVU, 32'd5,          32'd0,        3'd0, 32'hFFFFFFFF, 1, 1'b1);
        issue(OP_REM,  32'd5,          32'd0,        3'd1, 32'd5,        1, 1'b1);
        issue(OP_DIV,  32'h80000000,   32'hFFFFFFFF, 3'd2, 32'h80000000, 1, 1'b1);
        issue(OP_REM,  32'h80000000,   32'hFFFFFFFF, 3'd3, 32'd0,        1, 1'b1);
        wait_drain();

        // Reset in the middle of a divide: no writeback may ever appear for it.
        issue(OP_DIVU, 32'd1000, 32'd3, 3'd4, 32'd0, 33, 1'b0);
        repeat (9) @(negedge clk);
        rst_ni = 1'b0;
        #1;
        check("abort_ready", {31'd0, mdu_ready}, 32'd1);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_id", {29'd0, result_id}, 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {31'd0, mdu_ready}, 32'd1);
        repeat (40) @(negedge clk);

        // Back-to-back with a stray start while busy that must be ignored.
        issue(OP_MUL, 32'd3, 32'd4, 3'd6, 32'd12, 2, 1'b1);
        operation = OP_DIVU;
        operand_a = 32'd9;
        operand_b = 32'd0;
        trans_id  = 3'd1;
        mdu_valid = 1'b1;
        @(negedge clk);
        mdu_valid = 1'b0;
        issue(OP_DIVU, 32'd50, 32'd5, 3'd7, 32'd10, 33, 1'b1);
        wait_drain();
        repeat (5) @(negedge clk);
        check("wb_count", n_pop, n_push);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
